// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared types and constants for the memory bus arbiter
`ifndef CPU_DEFS_SV
`define CPU_DEFS_SV
`define ENABLE    1'b1
`define DISABLE   1'b0
`define ZERO_WORD 32'h0000_0000
`endif

package cpu_defs;
   typedef logic        Bit_t;
   typedef logic [31:0] Word_t;
   typedef logic [3:0]  Byte_en_t;

   typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DONE} Bus_state_t;
   typedef enum logic {GRANT_IF, GRANT_MEM} Grant_t;
endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - cycle counter that flags a bus access the slave never finishes
module bus_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [CNT_W-1:0] count;

   // Saturates at the expiry value so a stuck enable cannot wrap it back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM-style bus between instruction fetch and the MEM stage
module mem_bus_arbiter
   import cpu_defs::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_err,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_be,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        mem_err,
   output logic        bus_ce,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready,
   output logic        stall_req
);
   Bus_state_t state;
   Grant_t     last_grant;
   logic       in_access;
   logic       wd_expired;

   assign in_access = (state == IF_ACC) || (state == MEM_ACC);
   assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

   bus_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_access),
      .enable  (in_access),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_IF;
         if_rdata   <= `ZERO_WORD;
         if_ack     <= `DISABLE;
         if_err     <= `DISABLE;
         mem_rdata  <= `ZERO_WORD;
         mem_ack    <= `DISABLE;
         mem_err    <= `DISABLE;
         bus_ce     <= `DISABLE;
         bus_we     <= `DISABLE;
         bus_be     <= 4'h0;
         bus_addr   <= `ZERO_WORD;
         bus_wdata  <= `ZERO_WORD;
      end else begin
         case (state)
            IDLE: begin
               // On a tie MEM wins unless it won last time, so neither side starves.
               if (mem_req && (!if_req || last_grant == GRANT_IF)) begin
                  state     <= MEM_ACC;
                  bus_ce    <= `ENABLE;
                  bus_we    <= mem_we;
                  bus_be    <= mem_be;
                  bus_addr  <= mem_addr;
                  bus_wdata <= mem_wdata;
               end else if (if_req) begin
                  state     <= IF_ACC;
                  bus_ce    <= `ENABLE;
                  bus_we    <= `DISABLE;
                  bus_be    <= 4'hF;
                  bus_addr  <= if_addr;
                  bus_wdata <= `ZERO_WORD;
               end
            end
            IF_ACC: begin
               if (bus_ready || wd_expired) begin
                  state      <= DONE;
                  bus_ce     <= `DISABLE;
                  bus_we     <= `DISABLE;
                  last_grant <= GRANT_IF;
                  if_ack     <= `ENABLE;
                  if_err     <= !bus_ready;
                  if_rdata   <= bus_ready ? bus_rdata : `ZERO_WORD;
               end
            end
            MEM_ACC: begin
               if (bus_ready || wd_expired) begin
                  state      <= DONE;
                  bus_ce     <= `DISABLE;
                  bus_we     <= `DISABLE;
                  last_grant <= GRANT_MEM;
                  mem_ack    <= `ENABLE;
                  mem_err    <= !bus_ready;
                  mem_rdata  <= (bus_ready && !bus_we) ? bus_rdata : `ZERO_WORD;
               end
            end
            DONE: begin
               state     <= IDLE;
               if_ack    <= `DISABLE;
               if_err    <= `DISABLE;
               if_rdata  <= `ZERO_WORD;
               mem_ack   <= `DISABLE;
               mem_err   <= `DISABLE;
               mem_rdata <= `ZERO_WORD;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
   localparam int TIMEOUT = 64;

   logic        clk, rst;
   logic        if_req, if_ack, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        mem_req, mem_we, mem_ack, mem_err;
   logic [3:0]  mem_be, bus_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        bus_ce, bus_we, bus_ready, stall_req;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   int checks = 0;
   int errors = 0;
   bit last_mem = 1'b0;

   typedef struct {
      bit          ri;
      bit          rm;
      bit          we;
      logic [3:0]  be;
      logic [31:0] ia;
      logic [31:0] ma;
      logic [31:0] wd;
      logic [31:0] rd;
      int          k;
      bit          drop;
      bit          exp_mem;
   } vec_t;

   vec_t vecs[8];

   mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
      .bus_ce(bus_ce), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .stall_req(stall_req)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered and left at a negedge with the arbiter idle.
   task automatic do_txn(input vec_t v);
      bit          timeout;
      int          last;
      logic [31:0] exp_addr, exp_rd;
      if_req    = v.ri;
      mem_req   = v.rm;
      if_addr   = v.ia;
      mem_addr  = v.ma;
      mem_we    = v.we;
      mem_be    = v.be;
      mem_wdata = v.wd;
      bus_ready = 1'b0;
      #1 chk("stall_on_req", {31'd0, stall_req}, 32'd1);
      @(posedge clk); @(negedge clk);
      exp_addr = v.exp_mem ? v.ma : v.ia;
      chk("grant_ce", {31'd0, bus_ce}, 32'd1);
      chk("grant_we", {31'd0, bus_we}, {31'd0, v.exp_mem & v.we});
      chk("grant_addr", bus_addr, exp_addr);
      if (v.exp_mem) begin
         chk("grant_be", {28'd0, bus_be}, {28'd0, v.be});
         chk("grant_wdata", bus_wdata, v.wd);
      end
      timeout = (v.k >= TIMEOUT);
      last    = timeout ? TIMEOUT - 1 : v.k;
      for (int j = 0; j <= last; j++) begin
         bus_ready = (j == v.k);
         bus_rdata = (j == v.k) ? v.rd : $urandom;
         if (j == 0 && v.drop) begin
            if (v.exp_mem) mem_req = 1'b0;
            else           if_req  = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         if (j < last) begin
            chk("acc_ce", {31'd0, bus_ce}, 32'd1);
            chk("acc_addr", bus_addr, exp_addr);
            chk("acc_no_ack", {31'd0, if_ack | mem_ack}, 32'd0);
            chk("acc_stall", {31'd0, stall_req}, {31'd0, if_req | mem_req});
         end
      end
      bus_ready = 1'b0;
      exp_rd = (timeout || (v.exp_mem && v.we)) ? 32'd0 : v.rd;
      if (v.exp_mem) begin
         chk("mem_ack", {31'd0, mem_ack}, 32'd1);
         chk("mem_err", {31'd0, mem_err}, {31'd0, timeout});
         chk("mem_rdata", mem_rdata, exp_rd);
         chk("if_ack_quiet", {31'd0, if_ack}, 32'd0);
         chk("done_stall", {31'd0, stall_req}, {31'd0, if_req});
      end else begin
         chk("if_ack", {31'd0, if_ack}, 32'd1);
         chk("if_err", {31'd0, if_err}, {31'd0, timeout});
         chk("if_rdata", if_rdata, exp_rd);
         chk("mem_ack_quiet", {31'd0, mem_ack}, 32'd0);
         chk("done_stall", {31'd0, stall_req}, {31'd0, mem_req});
      end
      chk("done_ce", {31'd0, bus_ce}, 32'd0);
      last_mem  = v.exp_mem;
      if_req    = 1'b0;
      mem_req   = 1'b0;
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      chk("idle_acks", {30'd0, if_ack, mem_ack}, 32'd0);
      chk("idle_errs", {30'd0, if_err, mem_err}, 32'd0);
      chk("idle_ce", {31'd0, bus_ce}, 32'd0);
      chk("idle_stall", {31'd0, stall_req}, 32'd0);
      bus_ready = 1'b0;
   endtask

   initial begin
      vec_t v;
      int   sel;
      vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 32'h0, 32'h2402_0005, 1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h4000_0000, 32'h0, 32'h1111_2222, 0, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h4000_0004, 32'h0, 32'h3333_4444, 2, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h4000_0008, 32'h0, 32'h5555_6666, 1, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 4'b0011, 32'h0, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h8000_0020, 32'h0, 32'h0BAD_F00D, TIMEOUT - 1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h8000_0030, 32'h0, 32'h1234_5678, TIMEOUT, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_3000, 32'h0, 32'h0, 32'hCAFE_0001, 0, 1'b0, 1'b0};

      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
      bus_rdata = '0; bus_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ce", {31'd0, bus_ce}, 32'd0);
      chk("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
      chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) do_txn(vecs[i]);

      // Async reset in the middle of a MEM access.
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h9000_0000; mem_wdata = 32'h0F0F_0F0F;
      @(posedge clk); @(negedge clk);
      chk("prerst_ce", {31'd0, bus_ce}, 32'd1);
      @(posedge clk);
      #2 rst = 1'b1; mem_req = 1'b0;
      #1;
      chk("midrst_ce", {31'd0, bus_ce}, 32'd0);
      chk("midrst_we", {31'd0, bus_we}, 32'd0);
      chk("midrst_ack", {31'd0, mem_ack}, 32'd0);
      chk("midrst_stall", {31'd0, stall_req}, 32'd0);
      chk("midrst_addr", bus_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_mem = 1'b0;
      v = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h4000_1000, 32'h0, 32'h7777_8888, 1, 1'b0, 1'b1};
      do_txn(v);

      for (int n = 0; n < 40; n++) begin
         sel    = $urandom_range(1, 3);
         v.ri   = sel[0];
         v.rm   = sel[1];
         v.we   = 1'($urandom_range(0, 1));
         v.be   = 4'($urandom);
         v.ia   = $urandom;
         v.ma   = $urandom;
         v.wd   = $urandom;
         v.rd   = $urandom;
         v.k    = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 4));
         v.drop = 1'($urandom_range(0, 1));
         v.exp_mem = (v.ri && v.rm) ? !last_mem : v.rm;
         do_txn(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
